// File: rtl/ifetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifetch_stage_if                                               |
// | Purpose  : Instruction-memory, decode handshake and redirect bundle.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface ifetch_stage_if #(
   parameter int PC_WIDTH = 64
);
   logic                imem_req;
   logic [PC_WIDTH-1:0] imem_addr;
   logic                imem_rvalid;
   logic [31:0]         imem_rdata;
   logic [31:0]         ins;
   logic [PC_WIDTH-1:0] ins_pc;
   logic                ins_valid;
   logic                dec_ready;
   logic                br_taken;
   logic [PC_WIDTH-1:0] br_target;
   logic                fault;

   modport master (
      output imem_req, imem_addr, ins, ins_pc, ins_valid, fault,
      input  imem_rvalid, imem_rdata, dec_ready, br_taken, br_target
   );

   modport slave (
      input  imem_req, imem_addr, ins, ins_pc, ins_valid, fault,
      output imem_rvalid, imem_rdata, dec_ready, br_taken, br_target
   );
endinterface
`default_nettype wire

// File: rtl/ifetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifetch_stage                                                  |
// | Purpose  : 64-bit PC fetch stage, one outstanding imem request, valid/   |
// |            ready to decode, branch redirect. Optional macro             |
// |            IFETCH_MISALIGN_FAULT_EN enables sticky misaligned fault.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ifetch_stage #(
   parameter int                  PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  wire logic     clk,
   input  wire logic     reset,
   ifetch_stage_if.master bus
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } state_t;

   localparam logic [PC_WIDTH-1:0] c_pc_step = PC_WIDTH'(4);

   state_t              r_state, w_state_nxt;
   logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
   logic [31:0]         r_ins, w_ins_nxt;
   logic [PC_WIDTH-1:0] r_ins_pc, w_ins_pc_nxt;
   logic                r_ins_valid, w_ins_valid_nxt;
   logic [PC_WIDTH-1:0] w_target;
   logic                w_br;
   logic                w_req_ok;

`ifdef IFETCH_MISALIGN_FAULT_EN
   logic r_fault;

   // Once faulted the stage is frozen: redirects are ignored, no new fetches.
   assign w_br     = bus.br_taken && !r_fault;
   assign w_target = bus.br_target;
   assign w_req_ok = !r_fault;
   assign bus.fault = r_fault;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else if (w_br && (bus.br_target[1:0] != 2'b00)) begin
         r_fault <= 1'b1;
      end
   end
`else
   assign w_br      = bus.br_taken;
   assign w_target  = {bus.br_target[PC_WIDTH-1:2], 2'b00};
   assign w_req_ok  = 1'b1;
   assign bus.fault = 1'b0;
`endif

   assign bus.imem_req  = (r_state == S_REQ) && !bus.br_taken && w_req_ok;
   assign bus.imem_addr = r_pc;
   assign bus.ins       = r_ins;
   assign bus.ins_pc    = r_ins_pc;
   assign bus.ins_valid = r_ins_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_ins       <= '0;
         r_ins_pc    <= '0;
         r_ins_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_ins       <= w_ins_nxt;
         r_ins_pc    <= w_ins_pc_nxt;
         r_ins_valid <= w_ins_valid_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_ins_nxt       = r_ins;
      w_ins_pc_nxt    = r_ins_pc;
      w_ins_valid_nxt = r_ins_valid;

      if (w_br) begin
         w_pc_nxt = w_target;
      end

      case (r_state)
         S_REQ: begin
            if (!w_br && w_req_ok) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_br) begin
               w_state_nxt = bus.imem_rvalid ? S_REQ : S_DROP;
            end else if (bus.imem_rvalid) begin
               w_ins_nxt       = bus.imem_rdata;
               w_ins_pc_nxt    = r_pc;
               w_ins_valid_nxt = 1'b1;
               w_pc_nxt        = r_pc + c_pc_step;
               w_state_nxt     = S_HOLD;
            end
         end
         S_HOLD: begin
            if (w_br || bus.dec_ready) begin
               w_ins_valid_nxt = 1'b0;
               w_state_nxt     = S_REQ;
            end
         end
         S_DROP: begin
            // The stale response retires the outstanding request even when a
            // redirect lands in the same cycle; waiting longer would deadlock.
            if (bus.imem_rvalid) begin
               w_state_nxt = S_REQ;
            end
         end
         default: begin
            w_state_nxt = S_REQ;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ifetch_stage                                               |
// | Purpose  : Randomized bench for ifetch_stage against a flag-level model. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ifetch_stage;

   localparam int          PW  = 64;
   localparam logic [63:0] RPC = 64'h0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ifetch_stage_if #(.PC_WIDTH(PW)) bus ();

   ifetch_stage #(.PC_WIDTH(PW), .RESET_PC(RPC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: an in-flight request, whether its data is to be
   // discarded, whether an instruction is held for decode, and the fault flag.
   logic [63:0] m_pc, m_ins_pc;
   logic [31:0] m_ins;
   logic        m_out, m_disc, m_have, m_flt;
   logic        mem_pend;
   int          mem_cnt;

   logic [63:0] tgt_list [0:5];

   task automatic model_reset();
      m_pc = RPC; m_ins = '0; m_ins_pc = '0;
      m_out = 0; m_disc = 0; m_have = 0; m_flt = 0;
      mem_pend = 0; mem_cnt = 0;
   endtask

   initial begin
      logic        br, rdy, rv, exp_req, eff_br;
      logic [63:0] tgt;
      logic [31:0] rd;
      int          lat;

      tgt_list[0] = 64'h100;
      tgt_list[1] = 64'h200;
      tgt_list[2] = 64'hFFFF_FFFF_FFFF_FFF8;
      tgt_list[3] = 64'hFFFF_FFFF_FFFF_FFFC;
      tgt_list[4] = 64'h0000_0000_8000_0000;
      tgt_list[5] = 64'h40;

      reset = 1'b1;
      bus.br_taken = 0; bus.br_target = '0; bus.dec_ready = 0;
      bus.imem_rvalid = 0; bus.imem_rdata = '0;
      model_reset();

      repeat (2) @(negedge clk);
      #1;
      check_val("rst_ins_valid", bus.ins_valid, 1'b0);
      check_val("rst_ins", bus.ins, 32'h0);
      check_val("rst_ins_pc", bus.ins_pc, 64'h0);
      check_val("rst_addr", bus.imem_addr, RPC);
      check_val("rst_fault", bus.fault, 1'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc == 1200) begin
            reset = 1'b1;
            #1;
            check_val("midrst_ins_valid", bus.ins_valid, 1'b0);
            check_val("midrst_addr", bus.imem_addr, RPC);
            model_reset();
            @(negedge clk);
            reset = 1'b0;
         end

         // Stimulus
         br  = ($urandom_range(0, 99) < 8);
         tgt = ($urandom_range(0, 1) == 0) ? tgt_list[$urandom_range(0, 5)]
                                           : ({$urandom, $urandom} & ~64'h3);
         rdy = (cyc < 300) ? 1'b1 : ($urandom_range(0, 99) < 60);
         if (cyc >= 2000 && cyc <= 2012) begin
            br  = (cyc == 2000);
            tgt = 64'hFFFF_FFFF_FFFF_FFFC;
            rdy = 1'b1;
         end
         if (cyc >= 2900) begin
            br  = (cyc == 2900);
            tgt = 64'h102;
         end
         if (mem_pend) mem_cnt--;
         rv = mem_pend && (mem_cnt == 0);
         rd = $urandom;

         bus.br_taken = br; bus.br_target = tgt; bus.dec_ready = rdy;
         bus.imem_rvalid = rv; bus.imem_rdata = rd;
         #1;

         exp_req = !m_out && !m_have && !m_flt && !br;
         check_val("imem_req", bus.imem_req, exp_req);
         check_val("imem_addr", bus.imem_addr, m_pc);
         check_val("ins_valid", bus.ins_valid, m_have);
         check_val("ins", bus.ins, m_ins);
         check_val("ins_pc", bus.ins_pc, m_ins_pc);
         check_val("fault", bus.fault, m_flt);

         // Model update
`ifdef IFETCH_MISALIGN_FAULT_EN
         eff_br = br && !m_flt;
`else
         eff_br = br;
`endif
         if (eff_br) begin
`ifdef IFETCH_MISALIGN_FAULT_EN
            if (tgt[1:0] != 2'b00) m_flt = 1;
            m_pc = tgt;
`else
            m_pc = tgt & ~64'h3;
`endif
            m_have = 0;
            if (m_out) begin
               if (rv) begin m_out = 0; m_disc = 0; end
               else m_disc = 1;
            end
         end else if (m_out && rv) begin
            if (!m_disc) begin
               m_have = 1; m_ins = rd; m_ins_pc = m_pc; m_pc = m_pc + 64'd4;
            end
            m_out = 0; m_disc = 0;
         end else if (m_have && rdy) begin
            m_have = 0;
         end
         if (exp_req) begin
            m_out = 1; m_disc = 0;
         end

         if (rv) mem_pend = 0;
         if (exp_req) begin
            lat = (cyc < 300) ? 1 : $urandom_range(1, 3);
            mem_pend = 1; mem_cnt = lat;
         end

         @(negedge clk);
      end

`ifdef IFETCH_MISALIGN_FAULT_EN
      check_val("final_fault", bus.fault, 1'b1);
      check_val("final_addr", bus.imem_addr, 64'h102);
`else
      check_val("final_fault", bus.fault, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
